tx_cordic_rotator: RTL and testbench

//  Pipelined rotation-mode CORDIC: polar (magnitude, phase) -> cartesian (x, y).

---
 rtl/tx_cordic_rotator_if.sv | 22 ++
 rtl/tx_cordic_rotator.sv | 183 ++++++++++++++++++
 tb/tb_tx_cordic_rotator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_cordic_rotator_if.sv
// Sample-stream interface of tx_cordic_rotator: polar sample in (nd strobe), cartesian result out (rdy strobe).
interface tx_cordic_rotator_if #(
    parameter int DATA_W = 16
);
    logic                     nd;
    logic signed [DATA_W-1:0] mag_in;
    logic signed [15:0]       phase_in;
    logic                     rdy;
    logic signed [DATA_W-1:0] x_out;
    logic signed [DATA_W-1:0] y_out;
    logic                     phase_err;

    modport master (
        output nd, mag_in, phase_in,
        input  rdy, x_out, y_out, phase_err
    );

    modport slave (
        input  nd, mag_in, phase_in,
        output rdy, x_out, y_out, phase_err
    );
endinterface

// File: rtl/tx_cordic_rotator.sv
// Pipelined rotation-mode CORDIC: (magnitude, phase rad*2^13) -> saturated cartesian (x, y).
// Optional macro CORDIC_GAIN_COMP_EN adds a 1/K gain-compensation stage (latency ITERS+3 instead of ITERS+2).
module tx_cordic_rotator #(
    parameter int DATA_W = 16,
    parameter int ITERS  = 13,
    parameter int GUARD  = 2
) (
    input  logic               clk,
    input  logic               sclr,
    tx_cordic_rotator_if.slave bus
);
    localparam int IW = DATA_W + GUARD;
    // Phase accumulator carries two bits of headroom over the 16-bit input for the pre-rotation offset.
    localparam int ZW = 18;

    localparam logic signed [15:0] HALF_PI = 16'sd12868;
    localparam logic signed [15:0] PI_LIM  = 16'sd25736;

    localparam logic signed [ZW-1:0] ATAN [14] = '{
        18'sd6434, 18'sd3798, 18'sd2007, 18'sd1019, 18'sd511, 18'sd256, 18'sd128,
        18'sd64,   18'sd32,   18'sd16,   18'sd8,    18'sd4,   18'sd2,   18'sd1
    };

    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Stage k holds the sample after k micro-rotations; index 0 is the pre-rotated input.
    logic signed [IW-1:0] xs [ITERS+1];
    logic signed [IW-1:0] ys [ITERS+1];
    logic signed [ZW-1:0] zs [ITERS+1];
    logic [ITERS:0]       vs;
    logic [ITERS:0]       es;

    logic signed [IW-1:0] mag_ext;
    logic signed [ZW-1:0] ph_ext;
    logic signed [IW-1:0] x0_d;
    logic signed [IW-1:0] y0_d;
    logic signed [ZW-1:0] z0_d;
    logic                 err0_d;

    // Quadrant fold: bring |phase| within pi/2 so the micro-rotations can converge.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned (no latch).
        mag_ext = IW'(bus.mag_in);
        ph_ext  = ZW'(bus.phase_in);
        x0_d    = mag_ext;
        y0_d    = '0;
        z0_d    = ph_ext;
        if (bus.phase_in > HALF_PI) begin
            x0_d = '0;
            y0_d = mag_ext;
            z0_d = ph_ext - ZW'(HALF_PI);
        end else if (bus.phase_in < -HALF_PI) begin
            x0_d = '0;
            y0_d = -mag_ext;
            z0_d = ph_ext + ZW'(HALF_PI);
        end
        err0_d = (bus.phase_in > PI_LIM) || (bus.phase_in < -PI_LIM);
    end

    always_ff @(posedge clk or posedge sclr) begin
        // NOTE: data registers are cleared too, not just valid bits, so the whole datapath reads zero right after sclr.
        if (sclr) begin
            for (int i = 0; i <= ITERS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
                zs[i] <= '0;
            end
            vs <= '0;
            es <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the previous cycle's neighbour.
            vs <= {vs[ITERS-1:0], bus.nd};
            es[ITERS:1] <= es[ITERS-1:0];
            if (bus.nd) begin
                xs[0] <= x0_d;
                ys[0] <= y0_d;
                zs[0] <= z0_d;
                es[0] <= err0_d;
            end
            for (int i = 0; i < ITERS; i++) begin
                if (!zs[i][ZW-1]) begin
                    xs[i+1] <= xs[i] - (ys[i] >>> i);
                    ys[i+1] <= ys[i] + (xs[i] >>> i);
                    zs[i+1] <= zs[i] - ATAN[i];
                end else begin
                    xs[i+1] <= xs[i] + (ys[i] >>> i);
                    ys[i+1] <= ys[i] - (xs[i] >>> i);
                    zs[i+1] <= zs[i] + ATAN[i];
                end
            end
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int SW = IW + 16;
    localparam logic signed [SW-1:0] INV_K     = SW'(19898);
    localparam logic signed [SW-1:0] ROUND_ADD = SW'(16384);

    logic signed [SW-1:0] x_prod;
    logic signed [SW-1:0] y_prod;
    logic signed [SW-1:0] xg;
    logic signed [SW-1:0] yg;
    logic                 vg;
    logic                 eg;

    assign x_prod = SW'(xs[ITERS]) * INV_K;
    assign y_prod = SW'(ys[ITERS]) * INV_K;

    // Scale by 1/K in Q15 with round-half-up, cancelling the CORDIC gain.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            xg <= '0;
            yg <= '0;
            vg <= 1'b0;
            eg <= 1'b0;
        end else begin
            xg <= (x_prod + ROUND_ADD) >>> 15;
            yg <= (y_prod + ROUND_ADD) >>> 15;
            vg <= vs[ITERS];
            eg <= es[ITERS];
        end
    end

    logic signed [SW-1:0] fin_x;
    logic signed [SW-1:0] fin_y;
    logic                 fin_v;
    logic                 fin_e;

    assign fin_x = xg;
    assign fin_y = yg;
    assign fin_v = vg;
    assign fin_e = eg;
`else
    localparam int SW = IW;

    logic signed [SW-1:0] fin_x;
    logic signed [SW-1:0] fin_y;
    logic                 fin_v;
    logic                 fin_e;

    assign fin_x = xs[ITERS];
    assign fin_y = ys[ITERS];
    assign fin_v = vs[ITERS];
    assign fin_e = es[ITERS];
`endif

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SW'(OUT_MAX)) begin
            return OUT_MAX;
        end else if (v < SW'(OUT_MIN)) begin
            return OUT_MIN;
        end
        return DATA_W'(v);
    endfunction

    logic                     rdy_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] y_q;
    logic                     err_q;

    // Output register updates only for a valid sample and otherwise holds the last result.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            rdy_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
        end else begin
            rdy_q <= fin_v;
            if (fin_v) begin
                x_q   <= sat(fin_x);
                y_q   <= sat(fin_y);
                err_q <= fin_e;
            end
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.phase_err = err_q;
endmodule

// File: tb/tb_tx_cordic_rotator.sv
// Scoreboard bench for tx_cordic_rotator against a floating-point polar->cartesian model.
module tb_tx_cordic_rotator;
    localparam int DATA_W = 16;
    localparam int ITERS  = 13;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = ITERS + 3;
`else
    localparam int LAT = ITERS + 2;
`endif

    typedef struct {
        int issue;
        bit chk_xy;
        bit err;
        int ex;
        int ey;
        int tol;
    } exp_t;

    logic clk  = 1'b0;
    logic sclr = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    real  k_gain  = 1.0;
    real  gain    = 1.0;
    exp_t sb[$];

    tx_cordic_rotator_if #(.DATA_W(DATA_W)) bus ();

    tx_cordic_rotator #(
        .DATA_W(DATA_W),
        .ITERS (ITERS),
        .GUARD (2)
    ) dut (
        .clk (clk),
        .sclr(sclr),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int to_out(input real v);
        int r;
        r = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Issue one sample on nd and queue its ideal result; tol<0 picks a radius-scaled tolerance.
    task automatic send(input int mag, input int ph, input int tol);
        exp_t e;
        real  a;
        real  r;
        @(negedge clk);
        bus.nd       = 1'b1;
        bus.mag_in   = DATA_W'(mag);
        bus.phase_in = 16'(ph);
        a = real'(ph) / 8192.0;
        r = real'(mag) * gain;
        e.issue  = cyc;
        e.err    = (ph > 25736) || (ph < -25736);
        e.chk_xy = !e.err;
        e.ex     = to_out(r * $cos(a));
        e.ey     = to_out(r * $sin(a));
        e.tol    = (tol >= 0) ? tol : 8 + $rtoi((mag < 0 ? -mag : mag) * k_gain / 2048.0);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.nd = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        idle(1);
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        check("drain", sb.size() == 0, sb.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rdy"},       bus.rdy == 1'b0,       int'(bus.rdy),       0);
        check({tag, "_x_out"},     bus.x_out == '0,       int'(bus.x_out),     0);
        check({tag, "_y_out"},     bus.y_out == '0,       int'(bus.y_out),     0);
        check({tag, "_phase_err"}, bus.phase_err == 1'b0, int'(bus.phase_err), 0);
    endtask

    initial begin : monitor
        exp_t e;
        int   dx;
        int   dy;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rdy) begin
                check("spurious_rdy", sb.size() != 0, sb.size(), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("latency", (cyc - e.issue) == LAT, cyc - e.issue, LAT);
                    check("phase_err", bus.phase_err == e.err, int'(bus.phase_err), int'(e.err));
                    if (e.chk_xy) begin
                        dx = int'(bus.x_out) - e.ex;
                        dy = int'(bus.y_out) - e.ey;
                        check("x_out", dx <= e.tol && dx >= -e.tol, int'(bus.x_out), e.ex);
                        check("y_out", dy <= e.tol && dy >= -e.tol, int'(bus.y_out), e.ey);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion before cycle 40000");
        $fatal(1);
    end

    initial begin : stimulus
        real p;
        p = 1.0;
        for (int i = 0; i < ITERS; i++) begin
            k_gain = k_gain * $sqrt(1.0 + p);
            p = p / 4.0;
        end
`ifdef CORDIC_GAIN_COMP_EN
        gain = k_gain * 19898.0 / 32768.0;
`else
        gain = k_gain;
`endif
        bus.nd       = 1'b0;
        bus.mag_in   = '0;
        bus.phase_in = '0;

        #2 sclr = 1'b1;
        #1 check_zero_outputs("reset");

        // nd while sclr is high must be dropped: no scoreboard entry, so any rdy is spurious.
        @(negedge clk);
        bus.nd       = 1'b1;
        bus.mag_in   = 16'sd5000;
        bus.phase_in = 16'sd1000;
        @(negedge clk);
        bus.nd = 1'b0;
        sclr   = 1'b0;
        idle(LAT + 5);

        // Cardinal directions with the spec's +/-8 LSB tolerance.
        send(10000, 0, 8);
        idle(3);
        send(10000, 12868, 8);
        send(10000, -25735, 8);
        drain();

        // Saturation at 45 degrees, full-scale magnitude.
        send(32767, 6434, -1);
        send(-32768, -6434, -1);
        drain();

        // Out-of-range phase flagged, next legal sample clean.
        send(1000, 30000, 0);
        send(1000, 100, 8);
        drain();

        // Quadrant-fold and range boundaries.
        send(12000, 25736, -1);
        send(12000, -25736, -1);
        send(12000, 25737, -1);
        send(12000, -25737, -1);
        send(-12000, 12869, -1);
        send(12000, -12869, -1);
        send(12000, 12868, -1);
        drain();

        // Back-to-back random burst.
        for (int n = 0; n < 32; n++) begin
            send(int'($urandom_range(0, 39794)) - 19897, int'($urandom_range(0, 51472)) - 25736, -1);
        end
        drain();

        // Reset mid-stream discards all in-flight samples.
        for (int n = 0; n < 10; n++) begin
            send(int'($urandom_range(0, 39794)) - 19897, int'($urandom_range(0, 51472)) - 25736, -1);
        end
        idle(4);
        @(negedge clk);
        sclr = 1'b1;
        sb.delete();
        #1 check_zero_outputs("sclr_mid");
        @(negedge clk);
        @(negedge clk);
        sclr = 1'b0;
        idle(LAT + 10);

        send(10000, 3000, 8);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
